// File: rtl/framebuffer_writer_pkg.sv
// Shared framebuffer geometry, pixel type and writer state encoding.
// The VGA output path imports the same geometry constants.
package framebuffer_writer_pkg;

  localparam int unsigned FB_WIDTH  = 176;
  localparam int unsigned FB_HEIGHT = 144;
  localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned PIX_W     = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/framebuffer_writer_if.sv
// Framebuffer write port: the writer drives it, the RAM side consumes it.
interface framebuffer_writer_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  import framebuffer_writer_pkg::*;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  pixel_t                wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/framebuffer_writer_sync_edge_detect.sv
// Registers camera vsync/href and flags frame start, frame end and line end.
module framebuffer_writer_sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic href,
  output logic frame_start_c,
  output logic frame_end_c,
  output logic line_end_c
);

  logic vsync_q;
  logic href_q;

  // vsync idles high so a reset never fakes a frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b1;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
    end
  end

  assign frame_start_c = vsync_q & ~vsync;
  assign frame_end_c   = ~vsync_q & vsync;
  assign line_end_c    = href_q & ~href;

endmodule

// File: rtl/framebuffer_writer.sv
// Crops a window out of a camera pixel stream and writes it row-major into the framebuffer.
// Optional FRAMEBUFFER_WRITER_TEST_PATTERN_EN adds a test_pattern input (col ^ row data).
module framebuffer_writer #(
  parameter int unsigned FB_WIDTH   = framebuffer_writer_pkg::FB_WIDTH,
  parameter int unsigned FB_HEIGHT  = framebuffer_writer_pkg::FB_HEIGHT,
  parameter int unsigned H_OFFSET   = 0,
  parameter int unsigned V_OFFSET   = 0,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                           cam_pclk,
  input  logic                           reset,
  input  logic                           capture_en,
  input  logic                           cam_vsync,
  input  logic                           cam_href,
  input  framebuffer_writer_pkg::pixel_t din,
`ifdef FRAMEBUFFER_WRITER_TEST_PATTERN_EN
  input  logic                           test_pattern,
`endif
  framebuffer_writer_if.master           fb,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           frame_err
);
  import framebuffer_writer_pkg::*;

  localparam int unsigned SRC_W = 16;
  localparam int unsigned ROW_W = $clog2(FB_HEIGHT + 1);

  localparam logic [SRC_W-1:0]      H_LO     = SRC_W'(H_OFFSET);
  localparam logic [SRC_W-1:0]      H_HI     = SRC_W'(H_OFFSET + FB_WIDTH);
  localparam logic [SRC_W-1:0]      V_LO     = SRC_W'(V_OFFSET);
  localparam logic [ROW_W-1:0]      ROW_MAX  = ROW_W'(FB_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FB_WIDTH);

  state_t                state;
  logic [SRC_W-1:0]      col_src;
  logic [SRC_W-1:0]      row_src;
  logic [ROW_W-1:0]      row;
  logic [ADDR_WIDTH-1:0] row_base;

  logic                  frame_start_c;
  logic                  frame_end_c;
  logic                  line_end_c;
  logic                  in_vwin_c;
  logic                  in_hwin_c;
  logic                  pix_ok_c;
  logic [ROW_W-1:0]      row_nxt_c;
  logic [SRC_W-1:0]      col_c;
  pixel_t                pix_c;

  framebuffer_writer_sync_edge_detect u_edge (
    .clk           (cam_pclk),
    .rst           (reset),
    .vsync         (cam_vsync),
    .href          (cam_href),
    .frame_start_c (frame_start_c),
    .frame_end_c   (frame_end_c),
    .line_end_c    (line_end_c)
  );

  assign in_vwin_c = (row_src >= V_LO) && (row < ROW_MAX);
  assign in_hwin_c = (col_src >= H_LO) && (col_src < H_HI);
  assign pix_ok_c  = (state == CAPTURE) && cam_href && in_vwin_c && in_hwin_c;
  assign col_c     = col_src - H_LO;
  // Row count as it will be after this cycle; lets a line end and frame end coincide cleanly
  assign row_nxt_c = (line_end_c && in_vwin_c) ? row + ROW_W'(1) : row;

`ifdef FRAMEBUFFER_WRITER_TEST_PATTERN_EN
  assign pix_c = test_pattern ? (PIX_W'(col_c) ^ PIX_W'(row)) : din;
`else
  assign pix_c = din;
`endif

  always_ff @(posedge cam_pclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      col_src    <= '0;
      row_src    <= '0;
      row        <= '0;
      row_base   <= '0;
      fb.wr_en   <= 1'b0;
      fb.wr_addr <= '0;
      fb.wr_data <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      fb.wr_en   <= pix_ok_c;
      frame_done <= 1'b0;
      if (pix_ok_c) begin
        fb.wr_addr <= row_base + ADDR_WIDTH'(col_c);
        fb.wr_data <= pix_c;
      end

      case (state)
        IDLE: begin
          if (capture_en) state <= SYNC;
        end
        SYNC: begin
          if (!capture_en) begin
            state <= IDLE;
          end else if (frame_start_c) begin
            state    <= CAPTURE;
            busy     <= 1'b1;
            col_src  <= '0;
            row_src  <= '0;
            row      <= '0;
            row_base <= '0;
          end
        end
        CAPTURE: begin
          // Source counters saturate so an overlong line or frame cannot wrap back into the window
          if (line_end_c) begin
            col_src <= '0;
            if (row_src != '1) row_src <= row_src + SRC_W'(1);
            if (in_vwin_c) row_base <= row_base + ROW_STEP;
            row <= row_nxt_c;
          end else if (cam_href && (col_src != '1)) begin
            col_src <= col_src + SRC_W'(1);
          end
          if (frame_end_c || (row_nxt_c == ROW_MAX)) begin
            state      <= DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            frame_err  <= (row_nxt_c < ROW_MAX);
          end
        end
        DONE: begin
          state <= capture_en ? SYNC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
